// File: rtl/frame_size_encoder_if.sv
// Sample ingress / transform-size result bundle for frame_size_encoder.
//   master : drives sample_valid, sample_last, code_ready; observes the result side.
//   slave  : the encoder; consumes samples and drives the result holding register.
// Signals:
//   sample_valid  one sample accepted this cycle
//   sample_last   qualifies sample_valid: final sample of the frame
//   code_out      4-bit transform size code
//   code_valid    code_out holds an unconsumed result
//   code_ready    downstream accepts code_out when code_valid=1
//   size_err      qualifies code_out: measured length was unsupported
//   frame_drop    one-cycle pulse: a completed frame's result was discarded
interface frame_size_encoder_if;
  logic       sample_valid;
  logic       sample_last;
  logic [3:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       size_err;
  logic       frame_drop;

  modport master (
    output sample_valid, sample_last, code_ready,
    input  code_out, code_valid, size_err, frame_drop
  );

  modport slave (
    input  sample_valid, sample_last, code_ready,
    output code_out, code_valid, size_err, frame_drop
  );
endinterface

// File: rtl/frame_size_encoder.sv
// Measures the length of each sample frame and encodes it into the 4-bit transform
// size code (64->0110 ... 2048->1011). One result per frame is presented on a
// valid/ready holding register; a frame that completes while a result is still
// held and not being accepted is dropped and flagged on frame_drop.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  frame_size_encoder_if.slave (sample input, code result output)
// Build option:
//   FRAME_SIZE_ROUND_EN  round unsupported lengths 1..2048 up to the next supported
//                        size (err=0); longer frames give 1011 with err=1.
module frame_size_encoder #(
  parameter int unsigned CNT_W        = 12,
  parameter logic [3:0]  DEFAULT_CODE = 4'b1001
) (
  input logic                  clk,
  input logic                  rst,
  frame_size_encoder_if.slave  bus
);

  typedef enum logic [0:0] {StCount, StHold} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       code_q, code_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] count_inc;
  logic             frame_done;
  logic [3:0]       enc_code;
  logic             enc_err;

  // Saturating increment; also serves as the frame total on the last sample.
  assign count_inc  = (count_q == CntMax) ? count_q : count_q + CNT_W'(1);
  assign frame_done = bus.sample_valid & bus.sample_last;

  always_comb begin
    count_d = count_q;
    if (bus.sample_valid) begin
      count_d = bus.sample_last ? '0 : count_inc;
    end
  end

`ifdef FRAME_SIZE_ROUND_EN
  always_comb begin
    enc_err = 1'b0;
    if (count_inc <= CNT_W'(64)) begin
      enc_code = 4'b0110;
    end else if (count_inc <= CNT_W'(128)) begin
      enc_code = 4'b0111;
    end else if (count_inc <= CNT_W'(256)) begin
      enc_code = 4'b1000;
    end else if (count_inc <= CNT_W'(512)) begin
      enc_code = 4'b1001;
    end else if (count_inc <= CNT_W'(1024)) begin
      enc_code = 4'b1010;
    end else begin
      enc_code = 4'b1011;
      enc_err  = (count_inc > CNT_W'(2048));
    end
  end
`else
  always_comb begin
    enc_code = DEFAULT_CODE;
    enc_err  = 1'b1;
    case (count_inc)
      CNT_W'(64):   begin enc_code = 4'b0110; enc_err = 1'b0; end
      CNT_W'(128):  begin enc_code = 4'b0111; enc_err = 1'b0; end
      CNT_W'(256):  begin enc_code = 4'b1000; enc_err = 1'b0; end
      CNT_W'(512):  begin enc_code = 4'b1001; enc_err = 1'b0; end
      CNT_W'(1024): begin enc_code = 4'b1010; enc_err = 1'b0; end
      CNT_W'(2048): begin enc_code = 4'b1011; enc_err = 1'b0; end
      default:      ;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    err_d   = err_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StCount: begin
        if (frame_done) begin
          code_d  = enc_code;
          err_d   = enc_err;
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.code_ready) begin
          if (frame_done) begin
            // Accept and reload in the same cycle: no bubble.
            code_d = enc_code;
            err_d  = enc_err;
          end else begin
            state_d = StCount;
          end
        end else if (frame_done) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StCount;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCount;
      count_q <= '0;
      code_q  <= DEFAULT_CODE;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      code_q  <= code_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = (state_q == StHold);
  assign bus.size_err   = err_q;
  assign bus.frame_drop = drop_q;

endmodule

// File: tb/tb_frame_size_encoder.sv
module tb_frame_size_encoder;

  typedef struct {
    int         len;
    logic [3:0] code_s;
    logic       err_s;
    logic [3:0] code_r;
    logic       err_r;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  frame_size_encoder_if bus ();

  frame_size_encoder #(
    .CNT_W        (12),
    .DEFAULT_CODE (4'b1001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   drop_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Scoreboard: compare each result at the moment it is accepted.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.code_valid === 1'b1 && bus.code_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_code_out", 32'(bus.code_out), 32'(mon_e.code));
        chk("sb_size_err", 32'(bus.size_err), 32'(mon_e.err));
      end
    end
    if (rst === 1'b0 && bus.frame_drop === 1'b1) drop_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_last  = 1'b0;
      step();
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit push, input logic [3:0] c,
                            input logic e, input bit ready_on_last);
    for (int i = 0; i < len; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_last  = (i == len - 1);
      if (i == len - 1) begin
        if (ready_on_last) bus.code_ready = 1'b1;
        if (push) exp_q.push_back('{c, e});
      end
      step();
    end
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d",
             total_cnt, pass_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    //          len   strict      round
    vecs[0]  = '{64,   4'b0110, 1'b0, 4'b0110, 1'b0};
    vecs[1]  = '{128,  4'b0111, 1'b0, 4'b0111, 1'b0};
    vecs[2]  = '{256,  4'b1000, 1'b0, 4'b1000, 1'b0};
    vecs[3]  = '{512,  4'b1001, 1'b0, 4'b1001, 1'b0};
    vecs[4]  = '{1024, 4'b1010, 1'b0, 4'b1010, 1'b0};
    vecs[5]  = '{2048, 4'b1011, 1'b0, 4'b1011, 1'b0};
    vecs[6]  = '{100,  4'b1001, 1'b1, 4'b0111, 1'b0};
    vecs[7]  = '{3000, 4'b1001, 1'b1, 4'b1011, 1'b1};
    vecs[8]  = '{1,    4'b1001, 1'b1, 4'b0110, 1'b0};
    vecs[9]  = '{63,   4'b1001, 1'b1, 4'b0110, 1'b0};
    vecs[10] = '{65,   4'b1001, 1'b1, 4'b0111, 1'b0};
    vecs[11] = '{2049, 4'b1001, 1'b1, 4'b1011, 1'b1};
    vecs[12] = '{5000, 4'b1001, 1'b1, 4'b1011, 1'b1};  // counter saturates at 4095

    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
    bus.code_ready   = 1'b0;
    step();
    step();
    chk("rst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_code_out",   32'(bus.code_out),   32'h9);
    chk("rst_size_err",   32'(bus.size_err),   32'd0);
    chk("rst_frame_drop", 32'(bus.frame_drop), 32'd0);
    rst = 1'b0;

    // 256-sample frame: valid one cycle after last, for exactly one cycle.
    bus.code_ready = 1'b1;
    send_frame(256, 1'b1, 4'b1000, 1'b0, 1'b0);
    chk("lat1_code_valid", 32'(bus.code_valid), 32'd1);
    step();
    chk("one_cycle_valid", 32'(bus.code_valid), 32'd0);

    // Back-to-back frames from the table, downstream always ready.
    for (int i = 0; i < 13; i++) begin
`ifdef FRAME_SIZE_ROUND_EN
      send_frame(vecs[i].len, 1'b1, vecs[i].code_r, vecs[i].err_r, 1'b0);
`else
      send_frame(vecs[i].len, 1'b1, vecs[i].code_s, vecs[i].err_s, 1'b0);
`endif
    end
    step();
    step();

    // Held result with a second frame completing unaccepted -> drop.
    bus.code_ready = 1'b0;
    d0 = drop_seen;
    send_frame(2048, 1'b1, 4'b1011, 1'b0, 1'b0);
    chk("hold_valid", 32'(bus.code_valid), 32'd1);
    send_frame(64, 1'b0, 4'b0110, 1'b0, 1'b0);
    chk("drop_pulse", 32'(bus.frame_drop), 32'd1);
    step();
    chk("drop_single", 32'(bus.frame_drop), 32'd0);
    chk("held_code", 32'(bus.code_out), 32'hb);
    chk("held_valid", 32'(bus.code_valid), 32'd1);
    chk("drop_count", 32'(drop_seen - d0), 32'd1);
    bus.code_ready = 1'b1;
    step();
    chk("drop_released", 32'(bus.code_valid), 32'd0);

    // Accept and complete in the same cycle: result reloads, no drop.
    bus.code_ready = 1'b0;
    send_frame(256, 1'b1, 4'b1000, 1'b0, 1'b0);
    step();
    step();
    d0 = drop_seen;
    send_frame(512, 1'b1, 4'b1001, 1'b0, 1'b1);
    chk("b2b_valid", 32'(bus.code_valid), 32'd1);
    chk("b2b_code", 32'(bus.code_out), 32'h9);
    chk("b2b_err", 32'(bus.size_err), 32'd0);
    chk("b2b_no_drop", 32'(bus.frame_drop), 32'd0);
    step();
    chk("b2b_released", 32'(bus.code_valid), 32'd0);
    chk("b2b_drop_count", 32'(drop_seen - d0), 32'd0);

    // sample_last without sample_valid must not end the frame.
    send_samples(30);
    bus.sample_last = 1'b1;
    step();
    step();
    step();
    bus.sample_last = 1'b0;
    send_frame(34, 1'b1, 4'b0110, 1'b0, 1'b0);
    step();
    step();

    // Reset mid-frame discards the partial count.
    send_samples(300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.code_valid), 32'd0);
    send_frame(128, 1'b1, 4'b0111, 1'b0, 1'b0);
    step();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_size_encoder.md
Name: frame_size_encoder

Overview:
- Measures the length of each incoming sample frame and encodes it into the 4-bit transform size code used by the transform-size decode path.
- Code map: 64→0110, 128→0111, 256→1000, 512→1001, 1024→1010, 2048→1011.
- Sits on the sample ingress stream, ahead of the transform control logic.
- Presents one code per frame on a valid/ready output holding register.

Parameters:
- CNT_W, 12, width of the sample counter. Must be ≥12 so counts above 2048 can be represented.
- DEFAULT_CODE, 4'b1001, code emitted for unsupported frame lengths (512).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  one sample accepted this cycle.
- sample_last  input  1  qualifies sample_valid: this is the final sample of the frame.
- code_out  output  4  encoded transform size code.
- code_valid  output  1  code_out holds an unconsumed result.
- code_ready  input  1  downstream accepts code_out when code_valid=1.
- size_err  output  1  qualifies code_out: the measured length was unsupported.
- frame_drop  output  1  single-cycle pulse: a completed frame's result was discarded.

Behaviour:
- Reset, synchronous on rst=1 at the clk edge:
  - count=0, code_out=DEFAULT_CODE, code_valid=0, size_err=0, frame_drop=0, FSM=COUNT.
  - rst has priority over every other event, including mid-frame and during HOLD. A partial frame is discarded and the pending result is lost.
- Counter:
  - On sample_valid=1 with sample_last=0: count←count+1, saturating at 2^CNT_W−1.
  - On sample_valid=1 with sample_last=1: total=count+1 (saturating), then count←0.
  - sample_last is ignored when sample_valid=0.
- Encode of total:
  - Exact 64/128/256/512/1024/2048 → matching code, err=0.
  - Any other value (including 1..63 and >2048) → DEFAULT_CODE, err=1.
- FSM states:
  - COUNT: no result pending, code_valid=0.
  - HOLD: code_valid=1. code_out and size_err are stable until accepted.
- Transitions:
  - COUNT, frame completes → load code_out/size_err, go to HOLD. code_valid rises the cycle after the last sample (latency 1).
  - HOLD, code_ready=1, no completion this cycle → COUNT, code_valid=0 the next cycle.
  - HOLD, code_ready=1 and a completion in the same cycle → load the new result, stay in HOLD (back-to-back, no bubble).
  - HOLD, code_ready=0 and a completion → new result discarded, frame_drop=1 for one cycle. The held result is unchanged.
- The counter always runs, independent of FSM state. Counting of the next frame continues during HOLD.
- frame_drop is registered: it asserts the cycle after the dropped last sample.
- Single-sample frame (sample_valid & sample_last with count=0): total=1 → DEFAULT_CODE, err=1.

Optional Feature:
- Macro: FRAME_SIZE_ROUND_EN.
- Defined:
  - A non-power total of 1..2048 rounds up to the next supported size, with err=0. Totals ≤64 give 0110.
  - Totals >2048 give 1011 with err=1.
- Undefined: strict exact-match behaviour as described above.

Test Plan:
- Reset then 256 consecutive samples, last on the 256th, code_ready=1 → code_out=1000, size_err=0, code_valid high for exactly 1 cycle, 1 cycle after the last sample.
- Frame of 2048 samples, then a frame of 64 samples, code_ready held 0 until the second last arrives → first result 1011 held; frame_drop pulses once; code_out still 1011 after code_ready is raised.
- Frame of 100 samples → strict: code_out=1001, size_err=1. With FRAME_SIZE_ROUND_EN: code_out=0111, size_err=0.
- Frame of 3000 samples → code_out=1001, size_err=1. With FRAME_SIZE_ROUND_EN: code_out=1011, size_err=1.
- Result pending and code_ready=1 in the same cycle that a 512-sample frame ends → code_valid stays 1, code_out updates to 1001, no frame_drop.
- rst asserted after 300 samples of a frame, then a fresh 128-sample frame → no output for the aborted frame; code_out=0111, size_err=0.
